// File: rtl/m68k_z80_bus_bridge.sv
// rtl/m68k_z80_bus_bridge.sv - 68K-to-Z80 bus bridge (BUSREQ/RESET registers, 64 KB Z80 window); optional macro Z80_RESET_CTRL_EN
module m68k_z80_bus_bridge #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] m68_addr,
    input  logic        m68_as_n,
    input  logic        m68_uds_n,
    input  logic        m68_lds_n,
    input  logic        m68_rw,
    input  logic [15:0] m68_wdata,
    output logic [15:0] m68_rdata,
    output logic        m68_dtack_n,
    output logic        z80_busrq_n,
    input  logic        z80_busack_n,
    output logic        z80_reset_n,
    output logic [15:0] z80_addr,
    output logic [7:0]  z80_wdata,
    input  logic [7:0]  z80_rdata,
    output logic        z80_data_oe,
    output logic        z80_mreq_n,
    output logic        z80_rd_n,
    output logic        z80_wr_n
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REG        = 3'd1;
    localparam logic [2:0] S_WIN_SETUP  = 3'd2;
    localparam logic [2:0] S_WIN_STROBE = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_is_read;
    logic [15:0] r_rdata;
    logic        r_dtack_n;
    logic        r_busrq_n;
    logic [15:0] r_z80_addr;
    logic [7:0]  r_z80_wdata;
    logic        r_data_oe;
    logic        r_mreq_n;
    logic        r_rd_n;
    logic        r_wr_n;

    logic        w_hit_busreq;
    logic        w_hit_reset;
    logic        w_hit_win;
    logic        w_granted;
    logic        w_lane_lo;
    logic        w_any_lane;
    logic        w_ctrl_bit;
    logic [7:0]  w_byte;
    logic        w_unused;

    assign w_hit_busreq = (m68_addr[23:1] == 23'h508880);
`ifdef Z80_RESET_CTRL_EN
    assign w_hit_reset  = (m68_addr[23:1] == 23'h508900);
`else
    assign w_hit_reset  = 1'b0;
`endif
    assign w_hit_win    = (m68_addr[23:16] == 8'hA0);
    // Grant is only real once the Z80 has acknowledged our own request
    assign w_granted    = ~r_busrq_n & ~z80_busack_n;
    // Odd byte selected only when the low lane strobes alone
    assign w_lane_lo    = ~m68_lds_n & m68_uds_n;
    assign w_any_lane   = ~m68_uds_n | ~m68_lds_n;
    assign w_ctrl_bit   = w_lane_lo ? m68_wdata[0] : m68_wdata[8];
    assign w_byte       = w_lane_lo ? m68_wdata[7:0] : m68_wdata[15:8];
    assign w_unused     = m68_addr[0];

    // Access sequencer: decode in IDLE, run register or Z80 window cycle, hold DTACK until AS released
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_is_read   <= 1'b1;
            r_rdata     <= 16'h0000;
            r_dtack_n   <= 1'b1;
            r_busrq_n   <= 1'b1;
            r_z80_addr  <= 16'h0000;
            r_z80_wdata <= 8'h00;
            r_data_oe   <= 1'b0;
            r_mreq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!m68_as_n) begin
                        r_is_read <= m68_rw;
                        if (w_hit_busreq) begin
                            r_state <= S_REG;
                            if (!m68_rw && w_any_lane)
                                r_busrq_n <= ~w_ctrl_bit;
                            if (m68_rw)
                                r_rdata <= {7'b0, ~w_granted, 7'b0, ~w_granted};
                        end else if (w_hit_reset) begin
                            r_state <= S_REG;
                            if (m68_rw)
                                r_rdata <= 16'h0000;
                        end else if (w_hit_win) begin
                            if (w_granted) begin
                                r_state    <= S_WIN_SETUP;
                                r_z80_addr <= {m68_addr[15:1], w_lane_lo};
                                if (!m68_rw) begin
                                    r_z80_wdata <= w_byte;
                                    r_data_oe   <= 1'b1;
                                end
                            end else begin
                                // Window without the bus: acknowledge, float-high read, drop writes
                                r_state <= S_REG;
                                if (m68_rw)
                                    r_rdata <= 16'hFFFF;
                            end
                        end
                    end
                end
                S_REG: begin
                    if (m68_as_n) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state   <= S_DONE;
                        r_dtack_n <= 1'b0;
                    end
                end
                S_WIN_SETUP: begin
                    if (m68_as_n) begin
                        r_state   <= S_IDLE;
                        r_data_oe <= 1'b0;
                    end else begin
                        r_state  <= S_WIN_STROBE;
                        r_mreq_n <= 1'b0;
                        r_rd_n   <= ~r_is_read;
                        r_wr_n   <= r_is_read;
                        r_cnt    <= 4'(STROBE_CYCLES - 1);
                    end
                end
                S_WIN_STROBE: begin
                    if (m68_as_n) begin
                        r_state   <= S_IDLE;
                        r_mreq_n  <= 1'b1;
                        r_rd_n    <= 1'b1;
                        r_wr_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_state   <= S_DONE;
                        r_mreq_n  <= 1'b1;
                        r_rd_n    <= 1'b1;
                        r_wr_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_dtack_n <= 1'b0;
                        if (r_is_read)
                            r_rdata <= {z80_rdata, z80_rdata};
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (m68_as_n) begin
                        r_state   <= S_IDLE;
                        r_dtack_n <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef Z80_RESET_CTRL_EN
    logic r_z80_reset_n;

    // Z80 reset register: written on decode so an early AS release cannot lose it
    always_ff @(posedge clk) begin
        if (rst)
            r_z80_reset_n <= 1'b0;
        else if (r_state == S_IDLE && !m68_as_n && w_hit_reset && !m68_rw && w_any_lane)
            r_z80_reset_n <= w_ctrl_bit;
    end

    assign z80_reset_n = r_z80_reset_n;
`else
    assign z80_reset_n = ~rst;
`endif

    assign m68_rdata   = r_rdata;
    assign m68_dtack_n = r_dtack_n;
    assign z80_busrq_n = r_busrq_n;
    assign z80_addr    = r_z80_addr;
    assign z80_wdata   = r_z80_wdata;
    assign z80_data_oe = r_data_oe;
    assign z80_mreq_n  = r_mreq_n;
    assign z80_rd_n    = r_rd_n;
    assign z80_wr_n    = r_wr_n;

endmodule

// File: tb/tb_m68k_z80_bus_bridge.sv
// tb/tb_m68k_z80_bus_bridge.sv - scoreboard bench for m68k_z80_bus_bridge (honours Z80_RESET_CTRL_EN)
module tb_m68k_z80_bus_bridge;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] m68_addr;
    logic        m68_as_n, m68_uds_n, m68_lds_n, m68_rw;
    logic [15:0] m68_wdata;
    logic [15:0] m68_rdata;
    logic        m68_dtack_n;
    logic        z80_busrq_n, z80_busack_n, z80_reset_n;
    logic [15:0] z80_addr;
    logic [7:0]  z80_wdata, z80_rdata;
    logic        z80_data_oe, z80_mreq_n, z80_rd_n, z80_wr_n;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        chk;
        logic [15:0] rdata;
    } ack_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  len;
    } z80_ev_t;

    ack_t    ack_q[$];
    z80_ev_t z80_q[$];

    logic [2:0] busack_dly = 3'b111;

    m68k_z80_bus_bridge #(.STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .m68_addr(m68_addr), .m68_as_n(m68_as_n), .m68_uds_n(m68_uds_n), .m68_lds_n(m68_lds_n),
        .m68_rw(m68_rw), .m68_wdata(m68_wdata), .m68_rdata(m68_rdata), .m68_dtack_n(m68_dtack_n),
        .z80_busrq_n(z80_busrq_n), .z80_busack_n(z80_busack_n), .z80_reset_n(z80_reset_n),
        .z80_addr(z80_addr), .z80_wdata(z80_wdata), .z80_rdata(z80_rdata), .z80_data_oe(z80_data_oe),
        .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n)
    );

    always #5 clk = ~clk;

    // Z80 acknowledges bus requests three clocks late
    always @(posedge clk) busack_dly <= {busack_dly[1:0], z80_busrq_n};
    assign z80_busack_n = busack_dly[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // DTACK monitor: each acknowledge pops one expected response
    logic prev_dtack = 1'b1;
    always @(negedge clk) begin
        if (m68_dtack_n === 1'b0 && prev_dtack === 1'b1) begin
            if (ack_q.size() == 0) begin
                check("unexpected_dtack", 32'd1, 32'd0);
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                if (a.chk) check("m68_rdata", {16'h0, m68_rdata}, {16'h0, a.rdata});
            end
        end
        prev_dtack = m68_dtack_n;
    end

    // Z80 strobe monitor: measures each MREQ pulse and compares against the expected cycle
    int         ev_len = 0;
    logic       ev_wr, ev_rd, ev_oe;
    logic [15:0] ev_addr;
    logic [7:0]  ev_data;
    always @(negedge clk) begin
        if (z80_mreq_n === 1'b0) begin
            if (ev_len == 0) begin
                ev_addr = z80_addr;
                ev_data = z80_wdata;
                ev_wr   = ~z80_wr_n;
                ev_rd   = ~z80_rd_n;
                ev_oe   = z80_data_oe;
            end
            ev_len++;
        end else if (ev_len != 0) begin
            if (z80_q.size() == 0) begin
                check("unexpected_mreq", 32'd1, 32'd0);
            end else begin
                z80_ev_t e;
                e = z80_q.pop_front();
                check("z80_wr_strobe", {31'h0, ev_wr}, {31'h0, e.wr});
                check("z80_rd_strobe", {31'h0, ev_rd}, {31'h0, ~e.wr});
                check("z80_data_oe", {31'h0, ev_oe}, {31'h0, e.wr});
                check("z80_addr", {16'h0, ev_addr}, {16'h0, e.addr});
                check("strobe_len", ev_len, {24'h0, e.len});
                if (e.wr) check("z80_wdata", {24'h0, ev_data}, {24'h0, e.data});
            end
            ev_len = 0;
        end
    end

    task automatic bus(input logic [23:0] a, input logic rw, input logic uds_n, input logic lds_n,
                       input logic [15:0] wd, input logic exp_ack, input logic chk, input logic [15:0] exp_rd);
        bit got;
        got = 0;
        if (exp_ack) ack_q.push_back('{chk: chk, rdata: exp_rd});
        m68_addr = a; m68_rw = rw; m68_uds_n = uds_n; m68_lds_n = lds_n; m68_wdata = wd;
        m68_as_n = 1'b0;
        if (exp_ack) begin
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (m68_dtack_n === 1'b0) got = 1;
            end
            if (!got) begin
                check("dtack_timeout", 32'd0, 32'd1);
                void'(ack_q.pop_back());
            end else begin
                repeat (2) @(negedge clk);
                check("dtack_held", {31'h0, m68_dtack_n}, 32'd0);
            end
        end else begin
            repeat (20) @(negedge clk);
            check("no_dtack", {31'h0, m68_dtack_n}, 32'd1);
        end
        m68_as_n = 1'b1;
        repeat (2) @(negedge clk);
        check("dtack_release", {31'h0, m68_dtack_n}, 32'd1);
    endtask

    task automatic wait_mreq();
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (z80_mreq_n === 1'b0) got = 1;
        end
        if (!got) check("mreq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; m68_addr = '0; m68_as_n = 1'b1; m68_uds_n = 1'b1; m68_lds_n = 1'b1;
        m68_rw = 1'b1; m68_wdata = '0; z80_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_reset_n", {31'h0, z80_reset_n}, 32'd0);
        check("rst_busrq_n", {31'h0, z80_busrq_n}, 32'd1);
        check("rst_dtack_n", {31'h0, m68_dtack_n}, 32'd1);
        check("rst_rdata", {16'h0, m68_rdata}, 32'h0);
        check("rst_z80_addr", {16'h0, z80_addr}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busrq_n", {31'h0, z80_busrq_n}, 32'd1);
`ifdef Z80_RESET_CTRL_EN
        check("idle_reset_n", {31'h0, z80_reset_n}, 32'd0);
`else
        check("idle_reset_n", {31'h0, z80_reset_n}, 32'd1);
`endif
        check("idle_dtack_n", {31'h0, m68_dtack_n}, 32'd1);
        check("idle_strobes", {29'h0, z80_mreq_n, z80_rd_n, z80_wr_n}, 32'd7);
        check("idle_oe", {31'h0, z80_data_oe}, 32'd0);

        // Not granted yet
        bus(24'hA11100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101);
        bus(24'hA00000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
        bus(24'hA00002, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000);
        bus(24'hA12000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

        // Request the bus with a word write, then read back the granted status
        bus(24'hA11100, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 16'h0000);
        repeat (5) @(negedge clk);
        check("busrq_asserted", {31'h0, z80_busrq_n}, 32'd0);
        bus(24'hA11100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);

        // Granted window accesses
        z80_q.push_back('{wr: 1'b1, addr: 16'h1235, data: 8'h5A, len: 8'(SC)});
        bus(24'hA01235, 1'b0, 1'b1, 1'b0, 16'h005A, 1'b1, 1'b0, 16'h0000);
        check("z80_addr_hold", {16'h0, z80_addr}, 32'h1235);

        z80_rdata = 8'hC3;
        z80_q.push_back('{wr: 1'b0, addr: 16'h0010, data: 8'h00, len: 8'(SC)});
        bus(24'hA00010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC3C3);

        z80_q.push_back('{wr: 1'b1, addr: 16'h0020, data: 8'hBE, len: 8'(SC)});
        bus(24'hA00020, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0000);

        z80_rdata = 8'h7E;
        z80_q.push_back('{wr: 1'b0, addr: 16'h0030, data: 8'h00, len: 8'(SC)});
        bus(24'hA00031, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h7E7E);

        // Abort by releasing AS during the strobe
        z80_q.push_back('{wr: 1'b0, addr: 16'h0040, data: 8'h00, len: 8'd1});
        m68_addr = 24'hA00040; m68_rw = 1'b1; m68_uds_n = 1'b0; m68_lds_n = 1'b0;
        m68_as_n = 1'b0;
        wait_mreq();
        m68_as_n = 1'b1;
        @(negedge clk);
        check("abort_strobes", {29'h0, z80_mreq_n, z80_rd_n, z80_wr_n}, 32'd7);
        check("abort_state", {29'h0, dut.r_state}, 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_dtack", {31'h0, m68_dtack_n}, 32'd1);

        // Reset register
`ifdef Z80_RESET_CTRL_EN
        bus(24'hA11200, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 16'h0000);
        check("reset_reg_set", {31'h0, z80_reset_n}, 32'd1);
        bus(24'hA11201, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
`else
        bus(24'hA11200, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        check("reset_reg_absent", {31'h0, z80_reset_n}, 32'd1);
`endif

        // Low-lane BUSREQ writes: release then re-request
        bus(24'hA11101, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 16'h0000);
        check("busrq_release_lds", {31'h0, z80_busrq_n}, 32'd1);
        bus(24'hA11101, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0000);
        check("busrq_assert_lds", {31'h0, z80_busrq_n}, 32'd0);
        repeat (5) @(negedge clk);

        // Reset during the strobe
        z80_q.push_back('{wr: 1'b1, addr: 16'h0051, data: 8'h33, len: 8'd1});
        m68_addr = 24'hA00051; m68_rw = 1'b0; m68_uds_n = 1'b1; m68_lds_n = 1'b0; m68_wdata = 16'h0033;
        m68_as_n = 1'b0;
        wait_mreq();
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_strobes", {29'h0, z80_mreq_n, z80_rd_n, z80_wr_n}, 32'd7);
        check("rst_abort_oe", {31'h0, z80_data_oe}, 32'd0);
        check("rst_abort_state", {29'h0, dut.r_state}, 32'd0);
        check("rst_abort_busrq", {31'h0, z80_busrq_n}, 32'd1);
        check("rst_abort_dtack", {31'h0, m68_dtack_n}, 32'd1);
        rst = 1'b0;
        m68_as_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_abort_no_dtack", {31'h0, m68_dtack_n}, 32'd1);

        check("ack_queue_empty", ack_q.size(), 32'd0);
        check("z80_queue_empty", z80_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m68k_z80_bus_bridge.md
M68K_Z80_BUS_BRIDGE -- requirements
Module: m68k_z80_bus_bridge

Interface
REQ-001 Parameter: STROBE_CYCLES, default 2, clocks that Z80-side MREQ/RD/WR stay asserted per access (legal range 1..15).
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 m68_addr  in  24  68K byte address A23..A0.
REQ-005 m68_as_n, m68_uds_n, m68_lds_n  in  1 each  68K address strobe and byte strobes, active-low.
REQ-006 m68_rw  in  1  1=read, 0=write.
REQ-007 m68_wdata  in  16  68K write data; m68_rdata out 16 read data; m68_dtack_n out 1, active-low.
REQ-008 z80_busrq_n out 1; z80_busack_n in 1; z80_reset_n out 1; all active-low.
REQ-009 z80_addr out 16; z80_wdata out 8; z80_rdata in 8; z80_data_oe out 1.
REQ-010 z80_mreq_n, z80_rd_n, z80_wr_n  out  1 each  active-low Z80 memory strobes.

Function
REQ-011 Decode on m68_as_n=0 in IDLE: BUSREQ reg at 0xA11100/0xA11101; RESET reg at 0xA11200/0xA11201; window 0xA00000-0xA0FFFF; any other address: no response, stay IDLE.
REQ-012 FSM states IDLE, REG, WIN_SETUP, WIN_STROBE, DONE; every decoded access ends in DONE with m68_dtack_n=0 until m68_as_n=1, then IDLE next cycle.
REQ-013 Register access: IDLE->REG->DONE; dtack_n low 2 cycles after first as_n=0 sample.
REQ-014 BUSREQ write with uds_n=0: busrq_n <= ~wdata[8]; with lds_n=0 only: busrq_n <= ~wdata[0].
REQ-015 BUSREQ read: rdata = {7'b0, granted, 7'b0, granted} inverted as Genesis convention: bit8 and bit0 = 0 when busrq_n=0 and busack_n=0, else 1; other bits 0.
REQ-016 RESET write: z80_reset_n <= wdata[8] (uds) or wdata[0] (lds only); read returns 0x0000.
REQ-017 Window, bus not granted: IDLE->REG->DONE, read returns 0xFFFF, write dropped, no Z80 strobes.
REQ-018 Window, granted: IDLE->WIN_SETUP (drive z80_addr, z80_wdata, z80_data_oe for writes) ->WIN_STROBE (mreq_n=0 plus rd_n or wr_n=0 for STROBE_CYCLES clocks) ->DONE.
REQ-019 Byte lane: z80_addr = {A15..A1, 1'b1} if lds_n=0 and uds_n=1, else {A15..A1, 1'b0}; word write writes upper byte only; word write data uses wdata[15:8], lds-only write uses wdata[7:0].
REQ-020 Window read: z80_rdata sampled on last WIN_STROBE clock, returned replicated on both lanes {d,d}, held stable through DONE.
REQ-021 Strobes and z80_data_oe deassert on DONE entry; z80_addr holds last value.
REQ-022 Grant decided at IDLE decode; busack_n rising mid-access does not abort it.
REQ-023 m68_as_n=1 during REG/WIN_SETUP/WIN_STROBE: abort, all strobes and oe deasserted next cycle, return IDLE, no dtack, no register update if not yet committed (register writes commit on REG entry).
REQ-024 Back-to-back: a new as_n=0 is not decoded until IDLE reached after as_n=1.

Reset
REQ-025 rst=1 at a clock edge: state IDLE, m68_dtack_n=1, m68_rdata=0, z80_busrq_n=1, z80_reset_n=0, z80_mreq_n/rd_n/wr_n=1, z80_data_oe=0, z80_addr=0, z80_wdata=0.
REQ-026 rst mid-access forces REQ-025 values on that edge; pending access abandoned, no dtack.

Configuration
REQ-027 Macro Z80_RESET_CTRL_EN defined: RESET register per REQ-016 present.
REQ-028 Macro undefined: 0xA11200/0xA11201 not decoded (no dtack), z80_reset_n = 0 only while rst=1, else 1.

Verification
REQ-029 Reset then idle 10 cycles -> busrq_n=1, reset_n=0, dtack_n=1, all strobes 1.
REQ-030 Word write 0x0100 to 0xA11100, busack_n tied to busrq_n after 3 cycles, read 0xA11100 -> busrq_n=0, read data 0x0000; before grant read 0x0101.
REQ-031 Granted, byte write 0x5A (lds) to 0xA01235 -> z80_addr=0x1235, wdata=0x5A, wr_n low exactly STROBE_CYCLES clocks, dtack_n low until as_n=1.
REQ-032 Granted, word read 0xA00010, z80_rdata=0xC3 -> m68_rdata=0xC3C3, rd_n low STROBE_CYCLES clocks, z80_data_oe stays 0.
REQ-033 Not granted, read 0xA00000 -> 0xFFFF, no mreq; access to 0xA12000 -> no dtack for 20 cycles.
REQ-034 as_n released in WIN_STROBE, and separately rst asserted in WIN_STROBE -> strobes high next cycle, state IDLE, no dtack.
